// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolution side of the branch predictor. Every fetch-stage prediction is
// kept in an in-order queue. At EX the queue head is checked against the
// actual outcome. A mismatch raises flush and redirect. Every resolved
// conditional branch drives the predictor update port.
//
// Parameters
//   ADDR_W        instruction byte-address width
//   PQ_DEPTH      prediction queue entries (power of 2, >= 2)
//   FLUSH_CYCLES  cycles flush is held high after a mispredict (>= 1)
//
// Ports
//   clk, rst_n                         clock (rising edge), async active-low reset
//   if_push / if_pred_taken /
//   if_pred_target                     prediction pushed by IF
//   pq_full                            queue full, IF must stall (push is dropped)
//   ex_valid / ex_is_branch / ex_pc /
//   ex_taken / ex_target               outcome resolved at EX (pops the head)
//   flush                              kill younger instructions in IF/ID
//   redirect_valid / redirect_pc       one-cycle fetch restart pulse and address
//   upd_is_branch / upd_addr /
//   upd_next_addr / upd_is_suc         predictor training strobe and payload
//   err_underflow                      sticky: ex_valid seen with an empty queue
//   perf_branches / perf_mispred       saturating performance counters
//
// Configuration
//   BRU_PERF_CNT_EN  defined   : perf counters are built
//                    undefined : perf_branches / perf_mispred are tied to 0
//
// All outputs are registered. flush, redirect and update appear one cycle
// after the EX cycle that produced them.
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int ADDR_W       = 12,
    parameter int PQ_DEPTH     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    // IF side
    input  logic              if_push,
    input  logic              if_pred_taken,
    input  logic [ADDR_W-1:0] if_pred_target,
    output logic              pq_full,
    // EX side
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    // pipeline control
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    // predictor update
    output logic              upd_is_branch,
    output logic [ADDR_W-1:0] upd_addr,
    output logic [ADDR_W-1:0] upd_next_addr,
    output logic              upd_is_suc,
    // status
    output logic              err_underflow,
    output logic [15:0]       perf_branches,
    output logic [15:0]       perf_mispred
);

    localparam int PTR_W = $clog2(PQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PQ_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state;
    logic [FC_W-1:0]   flush_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              pq_taken  [PQ_DEPTH];
    logic [ADDR_W-1:0] pq_target [PQ_DEPTH];

    // -------------------------------------------------------------------------
    // Resolve / queue decisions for the current cycle
    // -------------------------------------------------------------------------
    logic              pq_empty;
    logic              count_full;
    logic              resolve;
    logic              pop;
    logic              push;
    logic              head_taken;
    logic [ADDR_W-1:0] head_target;
    logic              mispredict;
    logic [ADDR_W-1:0] correct_pc;
    logic [CNT_W-1:0]  count_next;

    assign pq_empty    = (count == '0);
    assign count_full  = (count == DEPTH_C);
    assign head_taken  = pq_taken[rd_ptr];
    assign head_target = pq_target[rd_ptr];

    // EX is only honoured in RUN. During FLUSH the resolving instruction
    // belongs to the killed wrong path.
    assign resolve = (state == ST_RUN) && ex_valid;
    assign pop     = resolve && !pq_empty;

    // A non-branch whose prediction said taken means the predictor aliased it
    // onto a branch entry. Fetch went somewhere wrong, so that is a mispredict too.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mispredict = 1'b0;
        if (pop) begin
            if (ex_is_branch) begin
                mispredict = (ex_taken != head_taken) ||
                             (ex_taken && (ex_target != head_target));
            end else begin
                mispredict = head_taken;
            end
        end
    end

    assign correct_pc = (ex_is_branch && ex_taken) ? ex_target
                                                   : ex_pc + ADDR_W'(4);

    // A push while full is only accepted if the head leaves in the same cycle.
    // The instruction fetched in the mispredict cycle is itself wrong-path,
    // so the clear wins over its push.
    assign push = if_push && !mispredict && (!count_full || pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // -------------------------------------------------------------------------
    // Queue storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is never read before it
    // has been written, because count/pointers (which are reset) gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pq_taken[wr_ptr]  <= if_pred_taken;
            pq_target[wr_ptr] <= if_pred_target;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM, queue pointers and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then sample the pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            flush_cnt      <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            pq_full        <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            upd_is_branch  <= 1'b0;
            upd_addr       <= '0;
            upd_next_addr  <= '0;
            upd_is_suc     <= 1'b0;
            err_underflow  <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            upd_is_branch  <= 1'b0;

            // Predictor training. Any conditional branch resolved in RUN trains
            // the predictor, whether or not it mispredicted.
            if (resolve && ex_is_branch) begin
                upd_is_branch <= 1'b1;
                upd_addr      <= ex_pc;
                upd_next_addr <= ex_target;
                upd_is_suc    <= ex_taken;
            end

            if (resolve && pq_empty) begin
                err_underflow <= 1'b1;
            end

            // Queue bookkeeping
            if (mispredict) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                pq_full <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count   <= count_next;
                pq_full <= (count_next == DEPTH_C);
            end

            // RUN -> FLUSH -> RUN. The cycles in which flush is high are exactly
            // the FLUSH cycles, so EX is ignored while younger work is killed.
            case (state)
                ST_RUN: begin
                    if (mispredict) begin
                        state          <= ST_FLUSH;
                        flush          <= 1'b1;
                        flush_cnt      <= FC_W'(FLUSH_CYCLES - 1);
                        redirect_valid <= 1'b1;
                        redirect_pc    <= correct_pc;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= ST_RUN;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else begin
            if (resolve && ex_is_branch && (perf_branches != 16'hFFFF)) begin
                perf_branches <= perf_branches + 16'd1;
            end
            if (mispredict && (perf_mispred != 16'hFFFF)) begin
                perf_mispred <= perf_mispred + 16'd1;
            end
        end
    end
`else
    assign perf_branches = '0;
    assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Self-checking bench for branch_resolve_unit. It runs a set of directed
// scenarios and then randomized traffic. Every cycle's outputs are compared
// against a reference model. The model is a queue of predictions plus a flush
// countdown.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int ADDR_W       = 12;
    localparam int PQ_DEPTH     = 4;
    localparam int FLUSH_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_push = 1'b0;
    logic              if_pred_taken = 1'b0;
    logic [ADDR_W-1:0] if_pred_target = '0;
    logic              pq_full;
    logic              ex_valid = 1'b0;
    logic              ex_is_branch = 1'b0;
    logic [ADDR_W-1:0] ex_pc = '0;
    logic              ex_taken = 1'b0;
    logic [ADDR_W-1:0] ex_target = '0;
    logic              flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              upd_is_branch;
    logic [ADDR_W-1:0] upd_addr;
    logic [ADDR_W-1:0] upd_next_addr;
    logic              upd_is_suc;
    logic              err_underflow;
    logic [15:0]       perf_branches;
    logic [15:0]       perf_mispred;

    branch_resolve_unit #(
        .ADDR_W      (ADDR_W),
        .PQ_DEPTH    (PQ_DEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_push       (if_push),
        .if_pred_taken (if_pred_taken),
        .if_pred_target(if_pred_target),
        .pq_full       (pq_full),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .upd_is_branch (upd_is_branch),
        .upd_addr      (upd_addr),
        .upd_next_addr (upd_next_addr),
        .upd_is_suc    (upd_is_suc),
        .err_underflow (err_underflow),
        .perf_branches (perf_branches),
        .perf_mispred  (perf_mispred)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct {
        bit          taken;
        int unsigned target;
    } pred_t;

    pred_t       mq[$];
    int          flush_left;
    bit          m_err;
    bit          m_rv;
    int unsigned m_rpc;
    bit          m_upd;
    int unsigned m_ua;
    int unsigned m_un;
    bit          m_us;
    int unsigned m_pb;
    int unsigned m_pm;

    function automatic void model_reset();
        mq.delete();
        flush_left = 0;
        m_err = 0; m_rv = 0; m_rpc = 0;
        m_upd = 0; m_ua = 0; m_un = 0; m_us = 0;
        m_pb = 0; m_pm = 0;
    endfunction

    // One clock edge worth of behaviour, using the inputs currently driven.
    function automatic void model_step();
        bit    mis;
        pred_t h;
        pred_t n;
        mis   = 0;
        m_rv  = 0;
        m_upd = 0;
        if (flush_left > 0) begin
            flush_left--;
        end else if (ex_valid) begin
            if (mq.size() == 0) begin
                m_err = 1;
            end else begin
                h = mq.pop_front();
                if (ex_is_branch)
                    mis = (ex_taken != h.taken) || (ex_taken && (int'(ex_target) != h.target));
                else
                    mis = h.taken;
            end
            if (ex_is_branch) begin
                m_upd = 1;
                m_ua  = ex_pc;
                m_un  = ex_target;
                m_us  = ex_taken;
                if (m_pb < 65535) m_pb++;
            end
            if (mis) begin
                mq.delete();
                flush_left = FLUSH_CYCLES;
                m_rv  = 1;
                m_rpc = (ex_is_branch && ex_taken) ? int'(ex_target)
                                                   : (int'(ex_pc) + 4) % (1 << ADDR_W);
                if (m_pm < 65535) m_pm++;
            end
        end
        if (if_push && !mis && (mq.size() < PQ_DEPTH)) begin
            n.taken  = if_pred_taken;
            n.target = if_pred_target;
            mq.push_back(n);
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".pq_full"},  32'(pq_full),        32'(mq.size() == PQ_DEPTH));
        check({tag, ".flush"},    32'(flush),          32'(flush_left > 0));
        check({tag, ".rv"},       32'(redirect_valid), 32'(m_rv));
        check({tag, ".rpc"},      32'(redirect_pc),    m_rpc);
        check({tag, ".upd"},      32'(upd_is_branch),  32'(m_upd));
        if (m_upd) begin
            check({tag, ".upd_addr"}, 32'(upd_addr),      m_ua);
            check({tag, ".upd_next"}, 32'(upd_next_addr), m_un);
            check({tag, ".upd_suc"},  32'(upd_is_suc),    32'(m_us));
        end
        check({tag, ".err"}, 32'(err_underflow), 32'(m_err));
`ifdef BRU_PERF_CNT_EN
        check({tag, ".perf_br"}, 32'(perf_branches), m_pb);
        check({tag, ".perf_mp"}, 32'(perf_mispred),  m_pm);
`else
        check({tag, ".perf_br"}, 32'(perf_branches), 32'd0);
        check({tag, ".perf_mp"}, 32'(perf_mispred),  32'd0);
`endif
    endtask

    // Drive one cycle of stimulus, advance the model, then sample after the edge.
    task automatic drive(input string tag,
                         input bit push, input bit pt, input logic [ADDR_W-1:0] ptgt,
                         input bit ev, input bit br, input logic [ADDR_W-1:0] pc,
                         input bit tk, input logic [ADDR_W-1:0] tgt);
        if_push        = push;
        if_pred_taken  = pt;
        if_pred_target = ptgt;
        ex_valid       = ev;
        ex_is_branch   = br;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        drive(tag, 0, 0, '0, 0, 0, '0, 0, '0);
    endtask

    // Reset asserts asynchronously away from the clock edge. Outputs are
    // checked while reset is still held, then it is released.
    task automatic do_reset(input string tag);
        if_push = 0; if_pred_taken = 0; if_pred_target = '0;
        ex_valid = 0; ex_is_branch = 0; ex_pc = '0; ex_taken = 0; ex_target = '0;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
        idle({tag, "_rel"});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #12;
        do_reset("reset");

        // Correct taken prediction: training only, no flush.
        drive("t1_push", 1, 1, 12'h040, 0, 0, '0, 0, '0);
        drive("t1_res",  0, 0, '0, 1, 1, 12'h03C, 1, 12'h040);
        idle("t1_idle");

        // Predicted not-taken, actually taken: redirect to target, flush 2 cycles.
        drive("t2_push", 1, 0, 12'h000, 0, 0, '0, 0, '0);
        drive("t2_res",  0, 0, '0, 1, 1, 12'h100, 1, 12'h200);
        idle("t2_fl1");
        idle("t2_fl2");

        // Taken with the wrong target. The push in the EX cycle is wrong-path and is cleared.
        drive("t3_push", 1, 1, 12'h080, 0, 0, '0, 0, '0);
        drive("t3_res",  1, 1, 12'h300, 1, 1, 12'h070, 1, 12'h0A0);
        idle("t3_fl1");
        idle("t3_fl2");

        // Aliased non-branch predicted taken: pc+4 wraps to zero, no training.
        drive("t4_push", 1, 1, 12'h500, 0, 0, '0, 0, '0);
        drive("t4_res",  0, 0, '0, 1, 0, 12'hFFC, 0, '0);
        idle("t4_fl1");
        idle("t4_fl2");

        // Queue empty after the flush: resolving now is an underflow, sticky.
        drive("t5_under", 0, 0, '0, 1, 0, 12'h010, 0, '0);
        idle("t5_sticky");

        // Fill, overfill, push+pop while full, then drain past empty.
        for (int i = 0; i < PQ_DEPTH + 1; i++)
            drive("t6_fill", 1, 0, 12'(i * 16), 0, 0, '0, 0, '0);
        drive("t6_pushpop", 1, 0, 12'h0F0, 1, 0, 12'h020, 0, '0);
        for (int i = 0; i < PQ_DEPTH + 1; i++)
            drive("t6_drain", 0, 0, '0, 1, 0, 12'(12'h100 + i * 4), 0, '0);

        do_reset("reset2");

        // Reset in the middle of a flush returns everything to zero.
        drive("t7_push", 1, 0, '0, 0, 0, '0, 0, '0);
        drive("t7_res",  0, 0, '0, 1, 1, 12'h444, 1, 12'h888);
        idle("t7_fl1");
        do_reset("reset_midflush");

        // Randomized traffic with a small target set so hits and misses both occur.
        for (int i = 0; i < 3000; i++) begin
            bit push, pt, ev, br, tk;
            logic [ADDR_W-1:0] ptgt, pc, tgt;
            push = ($urandom_range(0, 3) != 0);
            pt   = $urandom_range(0, 1);
            ptgt = ($urandom_range(0, 1) != 0) ? 12'h040 : 12'h080;
            ev   = ((mq.size() > 0) || (flush_left > 0)) && ($urandom_range(0, 2) != 0);
            br   = ($urandom_range(0, 3) != 0);
            tk   = $urandom_range(0, 1);
            tgt  = ($urandom_range(0, 1) != 0) ? 12'h040 : 12'h080;
            pc   = 12'($urandom_range(0, 4095)) & 12'hFFC;
            drive("rand", push, pt, ptgt, ev, br, pc, tk, tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
